// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO buffer slice: default geometry, occupancy
// counter type and the occupancy classification used by checkers and coverage.
package fifo_pkg;

    localparam int DEF_DEPTH    = 16;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_AF_LEVEL = 12;
    localparam int DEF_CW       = $clog2(DEF_DEPTH) + 1;

    typedef logic [DEF_CW-1:0] count_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_e;

    function automatic occ_e occ_of(input count_t cnt, input count_t depth);
        occ_e occ;
        if (cnt == count_t'(0)) begin
            occ = EMPTY;
        end else if (cnt == depth) begin
            occ = FULL;
        end else begin
            occ = PARTIAL;
        end
        return occ;
    endfunction

endpackage

// File: rtl/fifo_buf_if.sv
// Handshake and status bundle of the FIFO buffer; the producer/consumer side
// (master) drives the valid/ready requests, the buffer (slave) answers.
interface fifo_buf_if #(
    parameter int DEPTH = fifo_pkg::DEF_DEPTH,
    parameter int WIDTH = fifo_pkg::DEF_WIDTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             push;
    logic             pop;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic [CW-1:0]    peak_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, push, pop, count, almost_full, peak_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, push, pop, count, almost_full, peak_count
    );

endinterface

// File: rtl/fifo_buf_chk.sv
// Strobe legality and cross-check of the buffer occupancy against the
// downstream counter, sampled on the falling edge when everything is settled.
module fifo_buf_chk
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input logic                     clk,
    input logic                     rst_n,
    input logic                     push,
    input logic                     pop,
    input logic [$clog2(DEPTH):0]   count,
    input logic [$clog2(DEPTH):0]   ext_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    a_no_push_full: assert property (@(negedge clk) disable iff (!rst_n)
        !(push && count == DEPTH_C));

    a_no_pop_empty: assert property (@(negedge clk) disable iff (!rst_n)
        !(pop && count == {CW{1'b0}}));

    a_count_match: assert property (@(negedge clk) disable iff (!rst_n)
        count == ext_count);

    c_empty:   cover property (@(negedge clk) occ_of(count_t'(count), count_t'(DEPTH_C)) == EMPTY);
    c_partial: cover property (@(negedge clk) occ_of(count_t'(count), count_t'(DEPTH_C)) == PARTIAL);
    c_full:    cover property (@(negedge clk) occ_of(count_t'(count), count_t'(DEPTH_C)) == FULL);

endmodule

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end else begin
            r_mem[i_wr_addr] <= r_mem[i_wr_addr];
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_buf.sv
// First-word-fall-through FIFO buffer that emits push/pop strobes for the
// downstream occupancy counter and exports its own occupancy and peak.
module fifo_buf
    import fifo_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int AF_LEVEL = DEF_AF_LEVEL
) (
    input  logic      clk,
    input  logic      rst_n,
    fifo_buf_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_peak;
    logic [CW-1:0]    w_count_nxt;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_rd_data;

    // No full pass-through and no empty bypass: readiness depends only on state.
    assign w_in_ready  = rst_n && (r_count != DEPTH_C);
    assign w_out_valid = rst_n && (r_count != {CW{1'b0}});
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = bus.out_ready && w_out_valid;

    // Next occupancy from the strobes
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy and peak tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_peak   <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_peak  <= (w_count_nxt > r_peak) ? w_count_nxt : r_peak;
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.in_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = w_rd_data;
    assign bus.push        = w_push;
    assign bus.pop         = w_pop;
    assign bus.count       = r_count;
    assign bus.almost_full = rst_n && (r_count >= AF_C);
    assign bus.peak_count  = r_peak;

endmodule
